sc_wmux_accum: RTL and testbench

- Sequential, parametrised successor to the combinational weighted stochastic mux.
- Generates its own select sequence and selects one of 2^K weighted channels per clock.
- Emits the selected bit as a registered stochastic output stream, runs for a fixed 2^L-cycle stream length per request, and counts output ones.
- The count is a binary estimate of the scaled weighted sum. Sits between SC bitstream sources and SC-to-binary readout.

---
 rtl/sc_pkg.sv | 45 ++++
 rtl/sc_lfsr.sv | 51 +++++
 rtl/sc_wmux_accum.sv | 169 ++++++++++++++++
 tb/tb_sc_wmux_accum.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// sc_pkg: shared state encoding, channel-count helper and LFSR tap table
// for the sequential weighted stochastic mux (sc_wmux_accum) and sc_lfsr.
package sc_pkg;

    // Run controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sc_state_e;

    // Widths for which sc_lfsr_taps() knows a maximal-length polynomial
    localparam int SC_LFSR_MIN_W = 3;
    localparam int SC_LFSR_MAX_W = 16;

    // Number of mux channels for a K-bit select
    function automatic int sc_chan_count(input int k);
        return 1 << k;
    endfunction

    // Fibonacci feedback mask: bit i set means register bit i feeds the XOR.
    // The register shifts towards the MSB and the XOR result enters at bit 0.
    function automatic logic [31:0] sc_lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// sc_lfsr: WIDTH-bit maximal-length Fibonacci LFSR. load wins over en;
// reset and load both put SEED into the register. Used as the channel
// select source when SC_WMUX_LFSR_SEL_EN is defined.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEED  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    localparam logic [31:0]      TAPS_ALL = sc_lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);

    if (WIDTH < SC_LFSR_MIN_W || WIDTH > SC_LFSR_MAX_W) begin : g_bad_width
        $fatal(1, "sc_lfsr: WIDTH outside the supported tap table");
    end
    if (SEED_W == '0) begin : g_bad_seed
        $fatal(1, "sc_lfsr: an all-zero seed locks the LFSR");
    end

    logic [WIDTH-1:0] q_q, q_d;

    // Next value: reload, shift one step, or hold
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = SEED_W;
        end else if (en) begin
            q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
        end
    end

    // LFSR register, seeded on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= SEED_W;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sc_wmux_accum.sv
// sc_wmux_accum: sequential weighted stochastic mux with ones-counter.
// A start request launches a run of 2^L samples; each RUN cycle selects one
// of 2^K channels, registers din[sel] & weight[sel] onto dout and counts the
// ones. count holds the total of the last completed run.
// Optional: define SC_WMUX_LFSR_SEL_EN to take sel from the low K bits of an
// L-bit LFSR (seeded with SEED) instead of a K-bit up-counter.
module sc_wmux_accum
    import sc_pkg::*;
#(
    parameter int K    = 3,
    parameter int L    = 8,
    parameter int SEED = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [sc_chan_count(K)-1:0] din,
    input  logic [sc_chan_count(K)-1:0] weight,
    output logic                       dout,
    output logic                       dout_valid,
    output logic                       busy,
    output logic                       done,
    output logic [L:0]                 count
);

    if (K < 1 || L < K) begin : g_bad_params
        $fatal(1, "sc_wmux_accum: need K >= 1 and L >= K");
    end
    if ((SEED & ((1 << L) - 1)) == 0) begin : g_bad_seed
        $fatal(1, "sc_wmux_accum: SEED must be a nonzero L-bit value");
    end

    sc_state_e    state_q, state_d;
    logic [K-1:0] sel;
    logic [L-1:0] smp_cnt_q, smp_cnt_d;
    logic [L:0]   acc_q, acc_d;
    logic [L:0]   count_q, count_d;
    logic         dout_q, dout_d;
    logic         dout_valid_q, dout_valid_d;

    logic start_run;
    logic run_smp;
    logic last_smp;
    logic smp_bit;

    assign start_run = (state_q == IDLE) && start;
    assign run_smp   = (state_q == RUN);
    assign last_smp  = run_smp && (smp_cnt_q == '1);
    assign smp_bit   = din[sel] & weight[sel];

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every register in the
    // design updates from the same pre-edge values, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE on the last sample,
    // DONE -> IDLE unconditionally
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (smp_cnt_q == '1) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: clear on run start, sample and count in RUN
    always_comb begin
        smp_cnt_d    = smp_cnt_q;
        acc_d        = acc_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = run_smp;
        if (start_run) begin
            smp_cnt_d = '0;
            acc_d     = '0;
        end
        if (run_smp) begin
            dout_d    = smp_bit;
            acc_d     = acc_q + {{L{1'b0}}, smp_bit};
            smp_cnt_d = smp_cnt_q + L'(1);
        end
        if (last_smp) begin
            count_d = acc_q + {{L{1'b0}}, smp_bit};
        end
    end

    // Datapath registers; reset discards any partial run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_cnt_q    <= '0;
            acc_q        <= '0;
            count_q      <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            smp_cnt_q    <= smp_cnt_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

`ifdef SC_WMUX_LFSR_SEL_EN
    logic [L-1:0] lfsr_q;

    sc_lfsr #(
        .WIDTH (L),
        .SEED  (SEED)
    ) u_sel_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (start_run),
        .en   (run_smp),
        .q    (lfsr_q)
    );

    assign sel = lfsr_q[K-1:0];
`else
    logic [K-1:0] sel_q, sel_d;

    // Select counter next value: cleared on run start, advanced per sample
    always_comb begin
        sel_d = sel_q;
        if (start_run) begin
            sel_d = '0;
        end else if (run_smp) begin
            sel_d = sel_q + K'(1);
        end
    end

    // Select counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel = sel_q;
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign count      = count_q;

endmodule

// File: tb/tb_sc_wmux_accum.sv
// Testbench for sc_wmux_accum with K=3, L=4 (8 channels, 16-sample runs).
// Expected dout bits are queued when a run is launched and popped whenever
// the DUT shows dout_valid. Counts and timing come from a table plus a few
// hand-written sequences (mid-run reset, start held high).
module tb_sc_wmux_accum;

    localparam int K    = 3;
    localparam int L    = 4;
    localparam int SEED = 1;
    localparam int N    = 1 << K;
    localparam int S    = 1 << L;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] din;
    logic [N-1:0] weight;
    logic         dout;
    logic         dout_valid;
    logic         busy;
    logic         done;
    logic [L:0]   count;

    int n_cmp  = 0;
    int n_fail = 0;
    int prev_cnt = 0;
    logic exp_q[$];

    sc_wmux_accum #(
        .K    (K),
        .L    (L),
        .SEED (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din        (din),
        .weight     (weight),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference select for sample i of a run
    function automatic logic [K-1:0] model_sel(input int i);
`ifdef SC_WMUX_LFSR_SEL_EN
        logic [L-1:0] s;
        s = L'(SEED);
        for (int j = 0; j < i; j++) begin
            s = {s[L-2:0], s[L-1] ^ s[L-2]};  // x^4 + x^3 + 1
        end
        return s[K-1:0];
`else
        return K'(i % N);
`endif
    endfunction

    // Queue the expected bits of one run; return the model ones count
    function automatic int push_run(input logic [N-1:0] d, input logic [N-1:0] w);
        int ones;
        logic b;
        ones = 0;
        for (int i = 0; i < S; i++) begin
            b = d[model_sel(i)] & w[model_sel(i)];
            exp_q.push_back(b);
            ones += int'(b);
        end
        return ones;
    endfunction

    // Counter-select builds use the hand-derived constant, LFSR builds the model
    function automatic int pick(input int tbl_cnt, input int mdl_cnt);
`ifdef SC_WMUX_LFSR_SEL_EN
        return mdl_cnt;
`else
        return tbl_cnt;
`endif
    endfunction

    // Scoreboard: compare each visible sample with the queued expectation
    always @(negedge clk) begin
        if (rst === 1'b0 && dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_underflow: dout_valid with no expected sample (t=%0t)", $time);
            end else begin
                check("dout", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    // One pulsed-start run with latency, count and status checks
    task automatic run_once(input int idx, input logic [N-1:0] d, input logic [N-1:0] w,
                            input int tbl_cnt);
        int mdl;
        int exp_cnt;
        int cyc;
        logic last_bit;
        mdl      = push_run(d, w);
        exp_cnt  = pick(tbl_cnt, mdl);
        last_bit = exp_q[exp_q.size() - 1];
        din      = d;
        weight   = w;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("run%0d_busy", idx), 32'(busy), 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < S + 8) begin
            if (cyc == S / 2) check($sformatf("run%0d_count_held", idx), 32'(count), 32'(prev_cnt));
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("run%0d_done_latency", idx), 32'(cyc), 32'(S));
        check($sformatf("run%0d_count", idx), 32'(count), 32'(exp_cnt));
        check($sformatf("run%0d_busy_in_done", idx), 32'(busy), 32'd0);
        @(posedge clk); #1;
        check($sformatf("run%0d_done_pulse", idx), 32'(done), 32'd0);
        check($sformatf("run%0d_valid_drop", idx), 32'(dout_valid), 32'd0);
        check($sformatf("run%0d_dout_hold", idx), 32'(dout), 32'(last_bit));
        prev_cnt = exp_cnt;
    endtask

    typedef struct {
        logic [N-1:0] din;
        logic [N-1:0] weight;
        int           cnt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int cyc;
        int ndone;
        int first_done;
        int second_done;
        int mdl;
        int exp_cnt;

        tbl[0] = '{8'hFF, 8'hFF, 16};
        tbl[1] = '{8'hFF, 8'h0F, 8};
        tbl[2] = '{8'hAA, 8'hFF, 8};
        tbl[3] = '{8'h00, 8'hFF, 0};
        tbl[4] = '{8'h81, 8'hFF, 4};
        tbl[5] = '{8'hFF, 8'h01, 2};

        rst    = 1'b1;
        start  = 1'b0;
        din    = '0;
        weight = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_once(i, tbl[i].din, tbl[i].weight, tbl[i].cnt);
        end

        // Reset after five samples: abort, no done, count cleared
        void'(push_run(8'hFF, 8'hFF));
        din    = 8'hFF;
        weight = 8'hFF;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_dout", 32'(dout), 32'd0);
        check("abort_valid", 32'(dout_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        prev_cnt = 0;
        ndone = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        run_once(6, 8'hFF, 8'hFF, 16);

        // Start held high: one done per run, runs spaced 18 cycles
        mdl     = push_run(8'hFF, 8'h0F);
        void'(push_run(8'hFF, 8'h0F));
        exp_cnt = pick(8, mdl);
        din     = 8'hFF;
        weight  = 8'h0F;
        start   = 1'b1;
        @(posedge clk); #1;
        cyc         = 0;
        ndone       = 0;
        first_done  = -1;
        second_done = -1;
        while (ndone < 2 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) first_done = cyc;
                else second_done = cyc;
                check("hold_count", 32'(count), 32'(exp_cnt));
            end
        end
        start = 1'b0;
        check("hold_ndone", 32'(ndone), 32'd2);
        check("hold_first_done", 32'(first_done), 32'(S));
        check("hold_second_done", 32'(second_done), 32'(S + 18));
        repeat (3) @(posedge clk);
        #1;
        check("hold_no_requeue", 32'(busy), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard stop in case a bounded loop is somehow bypassed
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
